addr_reg_stack: RTL and testbench
=================================

Name: addr_reg_stack

Overview:
- Parametrised address register and successor to the single 2-source, load-only address register.
- Selects its load value from NSRC source buses, and adds auto-increment/decrement within a programmable window, wrap detection, and a DEPTH-entry save/restore stack for call/return sequencing.
- Sits in the processor datapath between the bus/immediate sources and memory addressing.

Parameters:
- WIDTH, 8, data/address width in bits.
- NSRC, 4, number of selectable load sources (2..16).
- SELW, 2, select width; must satisfy 2**SELW >= NSRC.
- DEPTH, 4, save/restore stack entries (1..16).
- STEP, 1, increment/decrement amount (1 <= STEP <= 2**WIDTH-1).
- RESET_VAL, 0, dout value after reset.

Ports:
- Clk  in  1  rising-edge clock.
- Rst  in  1  synchronous, active-high reset.
- WEN  in  1  operation enable; 0 = hold all state.
- Op  in  3  operation code (see Behaviour).
- Sel  in  SELW  source select; SrcIn slice Sel*WIDTH +: WIDTH.
- SrcIn  in  NSRC*WIDTH  concatenated source buses; source 0 in the LSBs.
- LimLo  in  WIDTH  window lower bound (inclusive).
- LimHi  in  WIDTH  window upper bound (inclusive).
- dout  out  WIDTH  current address.
- Wrap  out  1  one-cycle pulse when an inc/dec wrapped.
- Full  out  1  stack holds DEPTH entries.
- Empty  out  1  stack holds 0 entries.
- Err  out  1  sticky overflow/underflow/illegal-select flag.
- Level  out  5  current stack occupancy, 0..DEPTH.

Behaviour:
- All state updates on the rising edge of Clk. Outputs are registered, so changes are visible one cycle after the operation is sampled.
- Rst=1: dout=RESET_VAL, stack empty (Level=0, Empty=1, Full=0), Wrap=0, Err=0. Rst overrides WEN/Op in the same cycle, and discards stack contents mid-sequence.
- WEN=0: dout, stack and Err hold; Wrap=0.
- Op codes, applied only when WEN=1:
  - 000 HOLD: no change.
  - 001 LOAD: dout <= SrcIn[Sel].
  - 010 INC: compute n = {1'b0,dout} + STEP in WIDTH+1 bits. If n > {1'b0,LimHi}, dout <= LimLo and Wrap=1; else dout <= n[WIDTH-1:0].
  - 011 DEC: if {1'b0,dout} < {1'b0,LimLo} + STEP (WIDTH+1 bits), dout <= LimHi and Wrap=1; else dout <= dout - STEP.
  - 100 CALL: if !Full, push dout onto the stack, Level+1, and dout <= SrcIn[Sel] in the same cycle. If Full: no change to dout or stack, Err <= 1.
  - 101 RET: if !Empty, dout <= top entry, Level-1. If Empty: dout holds, Err <= 1.
  - 110 BASE: dout <= LimLo.
  - 111: reserved; treated as HOLD.
- Sel >= NSRC on LOAD or CALL: dout holds, stack unchanged, Err <= 1.
- The stack is LIFO, implemented as a register array with a Level pointer. Contents above Level are don't-care.
- Full = (Level==DEPTH); Empty = (Level==0). Both are combinational decodes of registered Level.
- Wrap is 0 in every cycle that did not wrap, including all non-INC/DEC ops.
- A dout outside [LimLo,LimHi] is legal:
  - INC from below the window steps normally until n > LimHi.
  - INC from above LimHi wraps immediately to LimLo.
  - DEC mirrors this.
- LimLo > LimHi is a software error. The comparisons above still apply literally; no extra checking.
- Err is cleared only by Rst.
- The stack must not alter dout except via RET.

Test Plan:
- Reset, WIDTH=8: Rst=1 for 1 cycle -> dout=0x00, Level=0, Empty=1, Full=0, Err=0, Wrap=0.
- LOAD each source: SrcIn={0x44,0x33,0x22,0x11}, Sel=0..3 with Op=001 -> dout=0x11,0x22,0x33,0x44 on successive cycles. Then Sel=2 with WEN=0 -> dout stays 0x44.
- INC wrap: LimLo=0x10, LimHi=0x13, dout=0x12, three INCs -> dout 0x13 (Wrap=0), 0x10 (Wrap=1), 0x11 (Wrap=0). DEC from 0x10 -> 0x13, Wrap=1.
- Top-of-range: LimHi=0xFF, LimLo=0x00, dout=0xFF, INC -> dout=0x00, Wrap=1; no truncation error from the 9-bit compare.
- Stack, DEPTH=4: CALL ×4 with SrcIn[0]=0xA0..0xA3 starting from dout=0x05 -> Full=1, Level=4. Fifth CALL -> dout unchanged (0xA3), Err=1. RET ×4 -> dout 0xA2, 0xA1, 0xA0, 0x05; Empty=1. Fifth RET -> dout 0x05, Err stays 1.
- Reset mid-sequence: after 2 CALLs, assert Rst together with Op=101 -> dout=RESET_VAL, Level=0, Err=0. A following RET sets Err=1.

Source files
------------

// File: rtl/addr_reg_stack.sv
// addr_reg_stack
//   Address register for the processor datapath. Loads from one of NSRC
//   source buses, auto-increments/decrements inside a [LimLo,LimHi] window
//   with wrap detection, and keeps a DEPTH-entry LIFO for call/return.
//
// Ports
//   Clk    : rising-edge clock
//   Rst    : synchronous active-high reset
//   WEN    : operation enable (0 = hold everything, Wrap low)
//   Op     : 000 HOLD, 001 LOAD, 010 INC, 011 DEC, 100 CALL, 101 RET,
//            110 BASE, 111 reserved (HOLD)
//   Sel    : source select into SrcIn
//   SrcIn  : NSRC concatenated WIDTH-bit sources, source 0 in the LSBs
//   LimLo  : window lower bound (inclusive)
//   LimHi  : window upper bound (inclusive)
//   dout   : current address (registered)
//   Wrap   : one-cycle pulse after an INC/DEC that wrapped
//   Full   : stack holds DEPTH entries
//   Empty  : stack holds no entries
//   Err    : sticky overflow/underflow/illegal-select flag, cleared by Rst
//   Level  : stack occupancy 0..DEPTH
module addr_reg_stack #(
  parameter int WIDTH     = 8,
  parameter int NSRC      = 4,
  parameter int SELW      = 2,
  parameter int DEPTH     = 4,
  parameter int STEP      = 1,
  parameter int RESET_VAL = 0
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic                  WEN,
  input  logic [2:0]            Op,
  input  logic [SELW-1:0]       Sel,
  input  logic [NSRC*WIDTH-1:0] SrcIn,
  input  logic [WIDTH-1:0]      LimLo,
  input  logic [WIDTH-1:0]      LimHi,
  output logic [WIDTH-1:0]      dout,
  output logic                  Wrap,
  output logic                  Full,
  output logic                  Empty,
  output logic                  Err,
  output logic [4:0]            Level
);

  localparam logic [2:0] OP_HOLD = 3'b000;
  localparam logic [2:0] OP_LOAD = 3'b001;
  localparam logic [2:0] OP_INC  = 3'b010;
  localparam logic [2:0] OP_DEC  = 3'b011;
  localparam logic [2:0] OP_CALL = 3'b100;
  localparam logic [2:0] OP_RET  = 3'b101;
  localparam logic [2:0] OP_BASE = 3'b110;

  localparam logic [WIDTH-1:0] STEP_N  = WIDTH'(STEP);
  localparam logic [WIDTH:0]   STEP_X  = {1'b0, STEP_N};
  localparam logic [WIDTH-1:0] RST_D   = WIDTH'(RESET_VAL);
  localparam logic [4:0]       DEPTH_L = 5'(DEPTH);

  logic [WIDTH-1:0] stack_mem [DEPTH];

  logic [WIDTH-1:0] src_val;
  logic             sel_bad;
  logic [WIDTH-1:0] top_val;
  logic [WIDTH:0]   inc_sum;
  logic             inc_wrap;
  logic             dec_wrap;
  logic             push;
  logic             pop;

  assign Full  = (Level == DEPTH_L);
  assign Empty = (Level == 5'd0);

  // Source mux written as a compare loop so an out-of-range Sel never
  // indexes past the end of SrcIn.
  always_comb begin
    src_val = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (32'(Sel) == i) src_val = SrcIn[i*WIDTH +: WIDTH];
    end
  end

  assign sel_bad = (32'(Sel) >= NSRC);

  // Entry just below Level is the top of stack.
  always_comb begin
    top_val = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (Level == 5'(i + 1)) top_val = stack_mem[i];
    end
  end

  // Compares are done one bit wider so a window ending at the top (or
  // starting at the bottom) of the address space still detects the wrap.
  assign inc_sum  = {1'b0, dout} + STEP_X;
  assign inc_wrap = (inc_sum > {1'b0, LimHi});
  assign dec_wrap = ({1'b0, dout} < ({1'b0, LimLo} + STEP_X));

  assign push = WEN && (Op == OP_CALL) && !Full && !sel_bad;
  assign pop  = WEN && (Op == OP_RET) && !Empty;

  always_ff @(posedge Clk) begin
    if (Rst) begin
      dout  <= RST_D;
      Wrap  <= 1'b0;
      Err   <= 1'b0;
      Level <= 5'd0;
    end else begin
      Wrap <= 1'b0;
      if (WEN) begin
        case (Op)
          OP_LOAD: begin
            if (sel_bad) Err <= 1'b1;
            else         dout <= src_val;
          end
          OP_INC: begin
            if (inc_wrap) begin
              dout <= LimLo;
              Wrap <= 1'b1;
            end else begin
              dout <= inc_sum[WIDTH-1:0];
            end
          end
          OP_DEC: begin
            if (dec_wrap) begin
              dout <= LimHi;
              Wrap <= 1'b1;
            end else begin
              dout <= dout - STEP_N;
            end
          end
          OP_CALL: begin
            if (Full || sel_bad) begin
              Err <= 1'b1;
            end else begin
              dout  <= src_val;
              Level <= Level + 5'd1;
            end
          end
          OP_RET: begin
            if (Empty) begin
              Err <= 1'b1;
            end else begin
              dout  <= top_val;
              Level <= Level - 5'd1;
            end
          end
          OP_BASE: dout <= LimLo;
          default: ;
        endcase
      end
    end
  end

  // Stack storage needs no reset: only entries below Level are ever read.
  always_ff @(posedge Clk) begin
    if (!Rst && push) begin
      for (int i = 0; i < DEPTH; i++) begin
        if (Level == 5'(i)) stack_mem[i] <= dout;
      end
    end
  end

  // pop is folded into the dout/Level update above.
  logic unused_ok;
  assign unused_ok = pop | (Op == OP_HOLD);

endmodule

// File: tb/tb_addr_reg_stack.sv
module tb_addr_reg_stack;

  logic        Clk = 1'b0;
  logic        Rst;
  logic        WEN;
  logic [2:0]  Op;
  logic [1:0]  Sel;
  logic [31:0] SrcIn;
  logic [7:0]  LimLo;
  logic [7:0]  LimHi;
  logic [7:0]  dout;
  logic        Wrap;
  logic        Full;
  logic        Empty;
  logic        Err;
  logic [4:0]  Level;

  int n_cmp = 0;
  int n_bad = 0;

  addr_reg_stack #(
    .WIDTH(8), .NSRC(4), .SELW(2), .DEPTH(4), .STEP(1), .RESET_VAL(0)
  ) dut (
    .Clk(Clk), .Rst(Rst), .WEN(WEN), .Op(Op), .Sel(Sel), .SrcIn(SrcIn),
    .LimLo(LimLo), .LimHi(LimHi), .dout(dout), .Wrap(Wrap), .Full(Full),
    .Empty(Empty), .Err(Err), .Level(Level)
  );

  always #5 Clk = ~Clk;

  task automatic step();
    @(posedge Clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] e_d, input logic e_w,
                         input logic [4:0] e_l, input logic e_err);
    chk({tag, ".dout"}, 32'(dout), 32'(e_d));
    chk({tag, ".wrap"}, 32'(Wrap), 32'(e_w));
    chk({tag, ".level"}, 32'(Level), 32'(e_l));
    chk({tag, ".full"}, 32'(Full), 32'(e_l == 5'd4));
    chk({tag, ".empty"}, 32'(Empty), 32'(e_l == 5'd0));
    chk({tag, ".err"}, 32'(Err), 32'(e_err));
  endtask

  initial begin
    Rst = 1'b1; WEN = 1'b0; Op = 3'b000; Sel = 2'd0;
    SrcIn = 32'h44332211; LimLo = 8'h00; LimHi = 8'hFF;
    step();
    chk_all("reset", 8'h00, 1'b0, 5'd0, 1'b0);

    // LOAD from each source, then WEN=0 holds
    Rst = 1'b0; WEN = 1'b1; Op = 3'b001;
    Sel = 2'd0; step(); chk_all("load0", 8'h11, 1'b0, 5'd0, 1'b0);
    Sel = 2'd1; step(); chk_all("load1", 8'h22, 1'b0, 5'd0, 1'b0);
    Sel = 2'd2; step(); chk_all("load2", 8'h33, 1'b0, 5'd0, 1'b0);
    Sel = 2'd3; step(); chk_all("load3", 8'h44, 1'b0, 5'd0, 1'b0);
    WEN = 1'b0; Sel = 2'd2; step(); chk_all("wen0", 8'h44, 1'b0, 5'd0, 1'b0);

    // INC wrap inside [0x10,0x13]
    WEN = 1'b1; LimLo = 8'h10; LimHi = 8'h13;
    SrcIn = 32'h44332212; Sel = 2'd0; Op = 3'b001;
    step(); chk("ld12", 32'(dout), 32'h12);
    Op = 3'b010;
    step(); chk_all("inc1", 8'h13, 1'b0, 5'd0, 1'b0);
    step(); chk_all("inc2", 8'h10, 1'b1, 5'd0, 1'b0);
    step(); chk_all("inc3", 8'h11, 1'b0, 5'd0, 1'b0);
    Op = 3'b110; step(); chk_all("base", 8'h10, 1'b0, 5'd0, 1'b0);
    Op = 3'b011; step(); chk_all("decwrap", 8'h13, 1'b1, 5'd0, 1'b0);
    step(); chk_all("decnorm", 8'h12, 1'b0, 5'd0, 1'b0);
    Op = 3'b111; step(); chk_all("rsvd", 8'h12, 1'b0, 5'd0, 1'b0);
    // INC from above the window wraps at once
    SrcIn = 32'h443322F0; Op = 3'b001; step();
    Op = 3'b010; step(); chk_all("inc_above", 8'h10, 1'b1, 5'd0, 1'b0);
    // INC from below the window steps normally
    SrcIn = 32'h44332203; Op = 3'b001; step();
    Op = 3'b010; step(); chk_all("inc_below", 8'h04, 1'b0, 5'd0, 1'b0);

    // Full-range window: 0xFF + 1 must wrap to 0x00
    LimLo = 8'h00; LimHi = 8'hFF;
    SrcIn = 32'h443322FF; Op = 3'b001; step();
    Op = 3'b010; step(); chk_all("inc_top", 8'h00, 1'b1, 5'd0, 1'b0);
    Op = 3'b011; step(); chk_all("dec_bot", 8'hFF, 1'b1, 5'd0, 1'b0);

    // Stack fill, overflow, drain, underflow
    SrcIn = 32'h44332205; Op = 3'b001; step();
    chk("ld05", 32'(dout), 32'h05);
    Op = 3'b100;
    SrcIn = 32'h443322A0; step(); chk_all("call0", 8'hA0, 1'b0, 5'd1, 1'b0);
    SrcIn = 32'h443322A1; step(); chk_all("call1", 8'hA1, 1'b0, 5'd2, 1'b0);
    SrcIn = 32'h443322A2; step(); chk_all("call2", 8'hA2, 1'b0, 5'd3, 1'b0);
    SrcIn = 32'h443322A3; step(); chk_all("call3", 8'hA3, 1'b0, 5'd4, 1'b0);
    SrcIn = 32'h443322B0; step(); chk_all("call_ovf", 8'hA3, 1'b0, 5'd4, 1'b1);
    Op = 3'b101;
    step(); chk_all("ret0", 8'hA2, 1'b0, 5'd3, 1'b1);
    step(); chk_all("ret1", 8'hA1, 1'b0, 5'd2, 1'b1);
    step(); chk_all("ret2", 8'hA0, 1'b0, 5'd1, 1'b1);
    step(); chk_all("ret3", 8'h05, 1'b0, 5'd0, 1'b1);
    step(); chk_all("ret_unf", 8'h05, 1'b0, 5'd0, 1'b1);
    WEN = 1'b0; step(); chk_all("err_sticky", 8'h05, 1'b0, 5'd0, 1'b1);

    // Reset in the middle of a call sequence
    Rst = 1'b1; step(); chk_all("rst2", 8'h00, 1'b0, 5'd0, 1'b0);
    Rst = 1'b0; WEN = 1'b1;
    SrcIn = 32'h44332207; Op = 3'b001; step();
    Op = 3'b100;
    SrcIn = 32'h443322C0; step();
    SrcIn = 32'h443322C1; step(); chk_all("mid_call", 8'hC1, 1'b0, 5'd2, 1'b0);
    Rst = 1'b1; Op = 3'b101; step(); chk_all("mid_rst", 8'h00, 1'b0, 5'd0, 1'b0);
    Rst = 1'b0; step(); chk_all("post_rst_ret", 8'h00, 1'b0, 5'd0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
